// File: rtl/ov7670_capture_ctrl.sv
// OV7670 capture sequencer: parses VSYNC/HREF/byte stream, packs RGB565 into RGB332, drives the frame-RAM write port.
// Build macro CAPTURE_DECIM_EN: store every second pixel of every second line from a 2*H_ACTIVE x 2*V_ACTIVE input.
module ov7670_capture_ctrl #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 15,
  parameter int H_ACTIVE      = 160,
  parameter int V_ACTIVE      = 120
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic [7:0]               cam_data,
  input  logic                     cap_start,
  input  logic                     cap_cont,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]     ram_data,
  output logic                     ram_we,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     ovf
);

`ifdef CAPTURE_DECIM_EN
  localparam int DS = 1;
`else
  localparam int DS = 0;
`endif
  localparam logic [15:0] H_LIM   = 16'(H_ACTIVE);
  localparam logic [15:0] V_LIM   = 16'(V_ACTIVE);
  localparam logic [15:0] ROW_MAX = 16'(V_ACTIVE << DS);
  localparam logic [RAM_ADDR_BITS-1:0] LINE_STEP = RAM_ADDR_BITS'(H_ACTIVE);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;
  state_t state_q, state_d;

  function automatic logic [RAM_WIDTH-1:0] pack_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

  logic                     vsync_p1, href_p1;
  logic                     vs_fall, vs_rise, href_fall;
  logic                     phase_p1;
  logic [7:0]               b0_p1;
  logic [15:0]              col_p1, row_p1, col_dec, row_dec;
  logic [RAM_ADDR_BITS-1:0] base_p1;
  logic                     keep, in_range, line_adv;

  assign vs_fall   = vsync_p1 & ~cam_vsync;
  assign vs_rise   = ~vsync_p1 & cam_vsync;
  assign href_fall = href_p1 & ~cam_href;
  assign col_dec   = col_p1 >> DS;
  assign row_dec   = row_p1 >> DS;
  assign in_range  = (col_dec < H_LIM) && (row_dec < V_LIM);

`ifdef CAPTURE_DECIM_EN
  assign keep     = ~col_p1[0] & ~row_p1[0];
  assign line_adv = ~row_p1[0];
`else
  assign keep     = 1'b1;
  assign line_adv = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE:    if (cap_start) state_d = WAIT_VS;
      WAIT_VS: begin
        busy = 1'b1;
        if (vs_fall) state_d = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (vs_rise) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = cap_cont ? WAIT_VS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // p1: edge-detect registers, byte pairing, line bookkeeping and the registered RAM write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_p1 <= 1'b0;
      href_p1  <= 1'b0;
      phase_p1 <= 1'b0;
      b0_p1    <= '0;
      col_p1   <= '0;
      row_p1   <= '0;
      base_p1  <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ovf      <= 1'b0;
    end else begin
      vsync_p1 <= cam_vsync;
      href_p1  <= cam_href;
      ram_we   <= 1'b0;
      if (state_q == IDLE && cap_start) ovf <= 1'b0;
      if (state_q == WAIT_VS && vs_fall) begin
        col_p1  <= '0;
        row_p1  <= '0;
        base_p1 <= '0;
      end
      if (state_q == CAPTURE && cam_href) begin
        phase_p1 <= ~phase_p1;
        if (!phase_p1) begin
          b0_p1 <= cam_data;
        end else begin
          if (keep && in_range) begin
            ram_we   <= 1'b1;
            ram_addr <= base_p1 + RAM_ADDR_BITS'(col_dec);
            ram_data <= pack_rgb332(b0_p1, cam_data);
          end else if (keep) begin
            ovf <= 1'b1;
          end
          if (col_p1 != 16'hFFFF) col_p1 <= col_p1 + 16'd1;
        end
      end else begin
        phase_p1 <= 1'b0;
        // Any line that produced pixels consumes a full RAM row, so short lines never shift the image
        if (state_q == CAPTURE && href_fall) begin
          col_p1 <= '0;
          if (col_p1 != '0 && row_p1 < ROW_MAX) begin
            row_p1 <= row_p1 + 16'd1;
            if (line_adv) base_p1 <= base_p1 + LINE_STEP;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed-vector bench for ov7670_capture_ctrl: camera byte-stream driver plus a RAM write logger.
module tb_ov7670_capture_ctrl;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cam_vsync, cam_href, cap_start, cap_cont;
  logic [7:0]    cam_data;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_we, busy, frame_done, ovf;

  ov7670_capture_ctrl #(.RAM_WIDTH(8), .RAM_ADDR_BITS(AW), .H_ACTIVE(160), .V_ACTIVE(120)) dut (
    .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .cap_start(cap_start), .cap_cont(cap_cont), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_we(ram_we), .busy(busy), .frame_done(frame_done), .ovf(ovf));

  always #5 clk = ~clk;

  logic [AW-1:0] log_addr[$];
  logic [7:0]    log_data[$];
  int            fd_cnt = 0;

  always @(negedge clk) begin
    if (ram_we) begin
      log_addr.push_back(ram_addr);
      log_data.push_back(ram_data);
    end
    if (frame_done) fd_cnt++;
  end

  int n_vec = 0;
  int n_err = 0;
  int line_len[0:255];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00; cap_start = 1'b0; cap_cont = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
  endtask

  // RGB332 value v is sent as the RGB565 pair that packs back to v
  task automatic send_pix(input logic [7:0] v);
    cam_href = 1'b1;
    cam_data = {v[7:5], 2'b00, v[4:2]};
    tick();
    cam_data = {3'b000, v[1:0], 3'b000};
    tick();
  endtask

  task automatic send_line(input int n, input bit pat);
    for (int i = 0; i < n; i++) send_pix(pat ? 8'(i) : 8'hE7);
    cam_href = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_begin();
    cam_vsync = 1'b1;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic run_frame(input int nl, input bit pat);
    frame_begin();
    for (int l = 0; l < nl; l++) send_line(line_len[l], pat);
    frame_end();
  endtask

  task automatic test_reset();
    reset_dut();
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %0b want 0", ram_we); end
    n_vec++; if (ram_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", ram_addr); end
    n_vec++; if (ram_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %0h want 0", ram_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", frame_done); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
  endtask

  task automatic test_full_frame();
    int w0, f0, nw, bad_d, bad_a;
    w0 = log_addr.size(); f0 = fd_cnt;
    pulse_start();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy_armed: got %0b want 1", busy); end
    for (int l = 0; l < 120; l++) line_len[l] = 160;
    run_frame(120, 1'b0);
    nw = log_addr.size() - w0;
    n_vec++; if (nw !== 19200) begin n_err++; $display("FAIL full_writes: got %0d want 19200", nw); end
    bad_d = 0; bad_a = 0;
    for (int k = 0; k < nw; k++) begin
      if (log_data[w0+k] !== 8'hE7) bad_d++;
      if (log_addr[w0+k] !== AW'(k)) bad_a++;
    end
    n_vec++; if (bad_d !== 0) begin n_err++; $display("FAIL full_data: %0d words differ from e7, want 0", bad_d); end
    n_vec++; if (bad_a !== 0) begin n_err++; $display("FAIL full_addr: %0d addresses out of sequence, want 0", bad_a); end
    n_vec++; if (fd_cnt - f0 !== 1) begin n_err++; $display("FAIL full_done: got %0d pulses want 1", fd_cnt - f0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_end: got %0b want 0", busy); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL full_ovf: got %0b want 0", ovf); end
  endtask

  task automatic test_short_line();
    int w0, nw;
    w0 = log_addr.size();
    pulse_start();
    for (int l = 0; l < 8; l++) line_len[l] = 160;
    line_len[5] = 100;
    run_frame(8, 1'b0);
    nw = log_addr.size() - w0;
    n_vec++; if (nw !== 1220) begin n_err++; $display("FAIL short_writes: got %0d want 1220", nw); end
    n_vec++; if (log_addr[w0+899] !== AW'(899)) begin n_err++; $display("FAIL short_last: got %0d want 899", log_addr[w0+899]); end
    n_vec++; if (log_addr[w0+900] !== AW'(960)) begin n_err++; $display("FAIL short_next: got %0d want 960", log_addr[w0+900]); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL short_ovf: got %0b want 0", ovf); end
  endtask

  task automatic test_long_line();
    int w0, nw;
    w0 = log_addr.size();
    pulse_start();
    line_len[0] = 170; line_len[1] = 160;
    run_frame(2, 1'b0);
    nw = log_addr.size() - w0;
    n_vec++; if (nw !== 320) begin n_err++; $display("FAIL long_writes: got %0d want 320", nw); end
    n_vec++; if (log_addr[w0+159] !== AW'(159)) begin n_err++; $display("FAIL long_last: got %0d want 159", log_addr[w0+159]); end
    n_vec++; if (log_addr[w0+160] !== AW'(160)) begin n_err++; $display("FAIL long_next: got %0d want 160", log_addr[w0+160]); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL long_ovf: got %0b want 1", ovf); end
    pulse_start();
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL long_ovf_clear: got %0b want 0", ovf); end
    run_frame(0, 1'b0);
  endtask

  task automatic test_continuous();
    int w0, f0, nw;
    w0 = log_addr.size(); f0 = fd_cnt;
    cap_cont = 1'b1;
    pulse_start();
    line_len[0] = 160; line_len[1] = 160;
    run_frame(2, 1'b0);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL cont_rearm_busy: got %0b want 1", busy); end
    run_frame(2, 1'b0);
    nw = log_addr.size() - w0;
    n_vec++; if (fd_cnt - f0 !== 2) begin n_err++; $display("FAIL cont_done: got %0d pulses want 2", fd_cnt - f0); end
    n_vec++; if (nw !== 640) begin n_err++; $display("FAIL cont_writes: got %0d want 640", nw); end
    n_vec++; if (log_addr[w0+320] !== AW'(0)) begin n_err++; $display("FAIL cont_restart: got %0d want 0", log_addr[w0+320]); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL cont_busy: got %0b want 1", busy); end
    cap_cont = 1'b0;
    run_frame(0, 1'b0);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cont_stop_busy: got %0b want 0", busy); end
  endtask

  task automatic test_reset_midframe();
    int w1, f1, nw;
    pulse_start();
    frame_begin();
    for (int l = 0; l < 3; l++) send_line(160, 1'b0);
    for (int i = 0; i < 50; i++) send_pix(8'hE7);
    rst_n = 1'b0;
    #1;
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0b want 0", ram_we); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
    repeat (2) tick();
    rst_n = 1'b1;
    w1 = log_addr.size(); f1 = fd_cnt;
    for (int i = 0; i < 20; i++) send_pix(8'hE7);
    cam_href = 1'b0;
    repeat (4) tick();
    frame_end();
    frame_begin();
    send_line(160, 1'b0);
    frame_end();
    n_vec++; if (log_addr.size() - w1 !== 0) begin n_err++; $display("FAIL rst_unarmed_writes: got %0d want 0", log_addr.size() - w1); end
    n_vec++; if (fd_cnt - f1 !== 0) begin n_err++; $display("FAIL rst_unarmed_done: got %0d want 0", fd_cnt - f1); end
    pulse_start();
    line_len[0] = 160;
    run_frame(1, 1'b0);
    nw = log_addr.size() - w1;
    n_vec++; if (nw !== 160) begin n_err++; $display("FAIL rst_rearm_writes: got %0d want 160", nw); end
    n_vec++; if (log_addr[w1] !== AW'(0)) begin n_err++; $display("FAIL rst_rearm_addr: got %0d want 0", log_addr[w1]); end
  endtask

  task automatic test_arm_collision();
    int w0, f0;
    w0 = log_addr.size(); f0 = fd_cnt;
    cam_vsync = 1'b0; cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    repeat (2) tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL coll_busy: got %0b want 1", busy); end
    send_line(160, 1'b0);
    frame_end();
    n_vec++; if (log_addr.size() - w0 !== 0) begin n_err++; $display("FAIL coll_writes: got %0d want 0", log_addr.size() - w0); end
    line_len[0] = 160;
    run_frame(1, 1'b0);
    n_vec++; if (log_addr.size() - w0 !== 160) begin n_err++; $display("FAIL coll_frame_writes: got %0d want 160", log_addr.size() - w0); end
    n_vec++; if (fd_cnt - f0 !== 1) begin n_err++; $display("FAIL coll_done: got %0d want 1", fd_cnt - f0); end
  endtask

  task automatic test_vsync_midline();
    int w0, f0, nw;
    w0 = log_addr.size(); f0 = fd_cnt;
    pulse_start();
    frame_begin();
    send_line(160, 1'b0);
    for (int i = 0; i < 9; i++) send_pix(8'hE7);
    cam_data = 8'hE5;
    tick();
    cam_data = 8'h18; cam_vsync = 1'b1;
    tick();
    cam_data = 8'hE5;
    tick();
    cam_href = 1'b0;
    repeat (4) tick();
    nw = log_addr.size() - w0;
    n_vec++; if (nw !== 170) begin n_err++; $display("FAIL vsmid_writes: got %0d want 170", nw); end
    n_vec++; if (log_addr[w0+169] !== AW'(169)) begin n_err++; $display("FAIL vsmid_addr: got %0d want 169", log_addr[w0+169]); end
    n_vec++; if (fd_cnt - f0 !== 1) begin n_err++; $display("FAIL vsmid_done: got %0d want 1", fd_cnt - f0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL vsmid_busy: got %0b want 0", busy); end
  endtask

  task automatic test_decimation();
    int w0, nw, bad;
    w0 = log_addr.size();
    pulse_start();
    for (int l = 0; l < 6; l++) line_len[l] = 320;
    run_frame(6, 1'b1);
    nw = log_addr.size() - w0;
    n_vec++; if (nw !== 480) begin n_err++; $display("FAIL dec_writes: got %0d want 480", nw); end
    bad = 0;
    for (int k = 0; k < 160; k++) if (log_data[w0+k] !== 8'(2*k) || log_addr[w0+k] !== AW'(k)) bad++;
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL dec_row0: %0d words wrong, want 0", bad); end
    n_vec++; if (log_addr[w0+160] !== AW'(160)) begin n_err++; $display("FAIL dec_row1_addr: got %0d want 160", log_addr[w0+160]); end
    n_vec++; if (log_data[w0+161] !== 8'd2) begin n_err++; $display("FAIL dec_row1_data: got %0h want 2", log_data[w0+161]); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL dec_ovf: got %0b want 0", ovf); end
  endtask

  initial begin
    test_reset();
`ifdef CAPTURE_DECIM_EN
    test_decimation();
`else
    test_full_frame();
    test_short_line();
    test_long_line();
    test_continuous();
    test_reset_midframe();
    test_arm_collision();
    test_vsync_midline();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
